multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Control sequencer for the multi-cycle variant of the RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- Steps one instruction through fetch/decode/execute/memory/writeback states.
- Drives per-state datapath selects and handshakes with a shared instruction/data memory through mem_req/mem_ready.
- ALU function decode (funct3/funct7 -> ALUControl) stays in the existing ALU decoder, which consumes ALUOp.

Parameters:
- STATE_W, 4, state register width (12 states used).
- ILLEGAL_TRAP, 1, when 1 an unknown opcode enters TRAP; when 0 it returns to FETCH, executing as a NOP.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  7  instr[6:0] from the instruction register, valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- mem_req  out  1  memory access request.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register / OldPC enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- RegWrite  out  1  register file write enable.
- Retire  out  1  one-cycle pulse in the final state of each instruction.
- Illegal  out  1  high while in TRAP.
- state_o  out  STATE_W  current state, for debug and the bench.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
- Reset: rst_n low asynchronously forces FETCH. Outputs are combinational from state, so in reset mem_req=1 and all strobes are 0 (PCWrite, IRWrite, MemWrite, RegWrite, Retire).
- Reset mid-instruction abandons it. No writeback occurs after reset is released.
- Every output not listed for a state is 0.

Per-state outputs and transitions:
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precomputes the branch target).
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - other -> TRAP, or FETCH with Retire=1 if ILLEGAL_TRAP=0
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Opcode 0000011 -> MEMREAD, else -> MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1 -> FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held every cycle until mem_ready. Retire=mem_ready. On mem_ready -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero, Retire=1 -> FETCH.
- TRAP: Illegal=1, absorbing. Only reset exits.

Other rules:
- ImmSrc is decoded combinationally from Opcode in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
- Cycle counts with zero-wait memory (mem_ready tied 1): lw 5, sw 4, R/I 4, jal 4, beq 3.
- Each memory wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE. Strobes stay stable while waiting.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Illegal state encodings (12-15) -> FETCH on the next edge.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH
  - state enum/localparams
  - ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings
- One sub-module, imm_src_decode: the combinational ImmSrc decoder, reusable by the single-cycle core. Next-state and output logic stay in this block.

Test Plan:
- Reset then lw with mem_ready=1 -> states 0,1,2,3,4,0. Exactly one RegWrite cycle with ResultSrc=01. Retire pulses once.
- sw with mem_ready low 2 cycles in MEMWRITE -> MemWrite=1 and AdrSrc=1 for 3 cycles. Retire only on the ready cycle. Next state FETCH.
- beq with zero=1 then zero=0 -> PCWrite=1 in BEQ only for zero=1. Both take 3 cycles. ALUOp=01.
- jal -> PCWrite in FETCH and JAL, then ALUWB with RegWrite=1 and ResultSrc=00. ImmSrc=11 throughout.
- Opcode 7'b1111111 with ILLEGAL_TRAP=1 -> TRAP, Illegal=1, no strobes for 10 cycles. With ILLEGAL_TRAP=0 -> FETCH after DECODE with Retire=1.
- rst_n asserted asynchronously in MEMREAD mid-wait -> state_o=0 immediately, RegWrite never asserted for that load.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I cores: opcodes, multicycle FSM states and
// the datapath select encodings driven by the control sequencer.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decode.sv
// Immediate format select from the opcode; shared with the single-cycle core.
module imm_src_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: steps each instruction through its
// states and drives the datapath selects and memory handshake.
module multicycle_control_fsm
  import core_pkg::*;
#(
  parameter int unsigned STATE_W      = 4,
  parameter bit          ILLEGAL_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         Opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               Retire,
  output logic               Illegal,
  output logic [STATE_W-1:0] state_o
);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state_o = STATE_W'(state_q);

  imm_src_decode u_imm (
    .opcode  (Opcode),
    .imm_src (ImmSrc)
  );

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    RegWrite  = 1'b0;
    Retire    = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes OldPC+imm so BEQ/JAL find the target in ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          default: begin
            if (ILLEGAL_TRAP) state_d = S_TRAP;
            else begin
              state_d = S_FETCH;
              Retire  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = zero;
        Retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: Illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Keep every write strobe quiet while reset is held, even if memory
    // signals ready into FETCH.
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Retire   = 1'b0;
    end
  end

endmodule
